io_port_bank: RTL and testbench
===============================

// Module: io_port_bank
// PURPOSE
//  Memory-mapped peripheral bank on the MMU I/O port (0x80000000-0x800000FF); consumes
//  io_addr/io_en/io_we/io_data_write, returns io_data_read. Holds GPIO out/in regs,
//  a FIFO-buffered 8N1 UART transmitter and a free-running 32-bit cycle counter.
//  Sits directly downstream of the MMU's registered I/O outputs; single clock domain.
// PARAMETERS
//  GPIO_W       8     width of gpio_out / gpio_in (1..32)
//  FIFO_DEPTH   8     TX FIFO entries (power of 2, >=2)
//  FIFO_LOG     3     log2(FIFO_DEPTH)
//  DEFAULT_DIV  104   UART_DIV reset value (clocks per bit)
// PORTS
//  clk            in   1        clock, all state on rising edge
//  reset          in   1        asynchronous, active-high reset
//  io_addr        in   8        byte offset in I/O window; [7:2] = register index, [1:0] ignored
//  io_en          in   1        access valid this cycle
//  io_we          in   1        1 = write, 0 = read (qualified by io_en)
//  io_data_write  in   32       write data (full word; software uses sw)
//  io_data_read   out  32       read data, combinational from io_addr
//  gpio_in        in   GPIO_W   asynchronous external inputs
//  gpio_out       out  GPIO_W   GPIO output register
//  uart_tx        out  1        serial line, idle high
// BEHAVIOUR
//  Register map (offset: access):
//   0x00 GPIO_OUT  RW  [GPIO_W-1:0]
//   0x04 GPIO_IN   RO  2-flop synchronised gpio_in
//   0x08 TXDATA    WO  push io_data_write[7:0]; reads {31'b0,tx_full}
//   0x0C STATUS    R/W1C  [0] tx_full [1] tx_empty [2] tx_busy [3] overflow (sticky)
//                  [8+:FIFO_LOG+1] FIFO count; write 1 to bit3 clears overflow
//   0x10 UART_DIV  RW  [15:0] clocks per bit; value 0 behaves as 1
//   0x14 CYCLE     RO  32-bit counter, +1 every clock, wraps 0xFFFFFFFF->0
//   others: read 32'b0, writes ignored.
//  Reads: io_data_read = mux(io_addr[7:2]) in the same cycle io_en is high; no side effects.
//   When io_en=0, io_data_read = 32'b0.
//  Writes: commit on the rising edge where io_en & io_we; visible on reads the next cycle.
//  Reset (async, immediate): gpio_out=0, gpio sync flops=0, FIFO empty, overflow=0,
//   UART_DIV=DEFAULT_DIV, CYCLE=0, TX FSM IDLE, uart_tx=1, io_data_read follows mux.
//  TX FIFO: circular, FIFO_LOG-bit pointers + count. Push on TXDATA write when not full;
//   push when full drops byte, sets overflow. Pop when FSM leaves IDLE.
//   Same-cycle push+pop on full FIFO: pop first, push accepted, count unchanged.
//  TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE/START.
//   IDLE: uart_tx=1; if FIFO non-empty pop head into shift reg, go START.
//   START: uart_tx=0 for one bit time. DATA: uart_tx=shift[0], shift right each bit.
//   STOP: uart_tx=1 one bit time; then START directly if FIFO non-empty (back-to-back,
//   no idle gap), else IDLE. Bit time = max(UART_DIV,1) clocks via down-counter.
//   UART_DIV sampled when each bit begins; mid-bit writes affect next bit only.
//   tx_busy = (state != IDLE). Frame latency: byte written at edge N -> start bit
//   asserted from edge N+2 (FIFO write, then IDLE pop).
// TESTING
//  T1 reset mid-frame: assert reset during DATA -> uart_tx=1, STATUS=0x0000_0002 same cycle.
//  T2 sw 0x55 to 0x08, DIV=4 -> uart_tx: 0 then 1,0,1,0,1,0,1,0 then 1, each 4 clocks; busy then idle.
//  T3 DIV=2, push 10 bytes back-to-back with FIFO_DEPTH=8 -> first pops immediately, 8 held,
//   10th dropped, STATUS[3]=1, count=8; write 0x8 to 0x0C clears bit3 only.
//  T4 two queued bytes 0xA5,0x3C -> stop bit of first followed directly by start of second, no gap.
//  T5 write 0xFF to 0x00 -> gpio_out=0xFF next cycle; gpio_in=0x5A -> read 0x04 = 0x5A after 2 clocks.
//  T6 force CYCLE near wrap (run 2^32 or preload via hierarchy) -> 0xFFFFFFFF then 0x0; read 0x40 -> 0.

Source files
------------

// File: rtl/io_port_bank_if.sv
// Bus between the MMU I/O window and the peripheral bank.
// The master drives address/strobe/write data; the slave answers with read data.
interface io_port_bank_if;
    logic [7:0]  io_addr;
    logic        io_en;
    logic        io_we;
    logic [31:0] io_data_write;
    logic [31:0] io_data_read;

    modport master (
        output io_addr,
        output io_en,
        output io_we,
        output io_data_write,
        input  io_data_read
    );

    modport slave (
        input  io_addr,
        input  io_en,
        input  io_we,
        input  io_data_write,
        output io_data_read
    );
endinterface

// File: rtl/io_port_bank.sv
// Peripheral bank on the MMU I/O window: GPIO out/in, FIFO-buffered 8N1 UART
// transmitter and a free-running cycle counter.
//
// TX FSM states
//   state    | meaning
//   ST_IDLE  | line idle high, waiting for a byte in the FIFO
//   ST_START | start bit (low) for one bit time
//   ST_DATA  | 8 data bits, LSB first, one bit time each
//   ST_STOP  | stop bit (high); chains straight into ST_START if FIFO not empty
//
// uart_tx is registered from the current state, so the line lags the FSM by
// one clock: a byte written at edge N pops at N+1 and drives the start bit from N+2.
module io_port_bank #(
    parameter int          GPIO_W      = 8,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          FIFO_LOG    = 3,
    parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
    input  logic              clk,
    input  logic              reset,
    io_port_bank_if.slave     bus,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              uart_tx
);

    localparam int CNT_W = FIFO_LOG + 1;

    localparam logic [5:0] IDX_GPIO_OUT = 6'd0;
    localparam logic [5:0] IDX_GPIO_IN  = 6'd1;
    localparam logic [5:0] IDX_TXDATA   = 6'd2;
    localparam logic [5:0] IDX_STATUS   = 6'd3;
    localparam logic [5:0] IDX_UART_DIV = 6'd4;
    localparam logic [5:0] IDX_CYCLE    = 6'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // register decode
    logic [5:0] reg_idx;
    logic       wr_en;
    logic       unused_bus_bits;

    assign reg_idx = bus.io_addr[7:2];
    assign wr_en   = bus.io_en & bus.io_we;
    // byte-lane bits and upper write data are don't-care for this bank
    assign unused_bus_bits = ^{bus.io_addr[1:0], bus.io_data_write[31:16]};

    // state
    logic [GPIO_W-1:0] gpio_out_q;
    logic [GPIO_W-1:0] gpio_meta_q;
    logic [GPIO_W-1:0] gpio_sync_q;
    logic [15:0]       uart_div_q;
    logic              overflow_q;
    logic [31:0]       cycle_q;

    logic [7:0]          fifo_mem [FIFO_DEPTH];
    logic [FIFO_LOG-1:0] wr_ptr_q;
    logic [FIFO_LOG-1:0] rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                fifo_full;
    logic                fifo_empty;
    logic [7:0]          fifo_head;
    logic                push_req;
    logic                push_ok;
    logic                pop;

    tx_state_t   state_q, state_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic [15:0] bit_reload;
    logic        bit_done;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign fifo_head  = fifo_mem[rd_ptr_q];
    assign push_req   = wr_en & (reg_idx == IDX_TXDATA);
    // a pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign push_ok    = push_req & (~fifo_full | pop);

    // a divider of 0 still gives one clock per bit
    assign bit_reload = (uart_div_q == 16'd0) ? 16'd0 : (uart_div_q - 16'd1);
    assign bit_done   = (bit_cnt_q == 16'd0);

    // GPIO output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out_q <= '0;
        end else if (wr_en && reg_idx == IDX_GPIO_OUT) begin
            gpio_out_q <= bus.io_data_write[GPIO_W-1:0];
        end
    end

    // two-flop synchroniser for the asynchronous GPIO inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_meta_q <= '0;
            gpio_sync_q <= '0;
        end else begin
            gpio_meta_q <= gpio_in;
            gpio_sync_q <= gpio_meta_q;
        end
    end

    // UART divider and sticky overflow flag (set on dropped push, W1C on bit 3)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uart_div_q <= DEFAULT_DIV;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en && reg_idx == IDX_UART_DIV) begin
                uart_div_q <= bus.io_data_write[15:0];
            end
            if (push_req && !push_ok) begin
                overflow_q <= 1'b1;
            end else if (wr_en && reg_idx == IDX_STATUS && bus.io_data_write[3]) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // free-running cycle counter, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    // FIFO storage; contents are don't-care until written so no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= bus.io_data_write[7:0];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + FIFO_LOG'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_LOG'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // TX FSM state register and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // TX FSM next state, bit timer, shift register and FIFO pop
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        tx_d      = 1'b1;

        case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
            default:  tx_d = 1'b1;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_head;
                    bit_cnt_d = bit_reload;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    bit_cnt_d = bit_reload;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    bit_cnt_d = bit_reload;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_d   = fifo_head;
                        bit_cnt_d = bit_reload;
                        state_d   = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // read mux, combinational from the address; zero when no access
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        if (bus.io_en) begin
            case (reg_idx)
                IDX_GPIO_OUT: rdata[GPIO_W-1:0] = gpio_out_q;
                IDX_GPIO_IN:  rdata[GPIO_W-1:0] = gpio_sync_q;
                IDX_TXDATA:   rdata[0] = fifo_full;
                IDX_STATUS: begin
                    rdata[0]         = fifo_full;
                    rdata[1]         = fifo_empty;
                    rdata[2]         = (state_q != ST_IDLE);
                    rdata[3]         = overflow_q;
                    rdata[8 +: CNT_W] = count_q;
                end
                IDX_UART_DIV: rdata[15:0] = uart_div_q;
                IDX_CYCLE:    rdata = cycle_q;
                default:      rdata = '0;
            endcase
        end
    end

    assign bus.io_data_read = rdata;
    assign gpio_out         = gpio_out_q;
    assign uart_tx          = tx_q;

endmodule

// File: tb/tb_io_port_bank.sv
module tb_io_port_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;
    logic       uart_tx;

    io_port_bank_if bus();

    io_port_bank #(
        .GPIO_W      (8),
        .FIFO_DEPTH  (8),
        .FIFO_LOG    (3),
        .DEFAULT_DIV (16'd104)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .uart_tx  (uart_tx)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        en;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[21];
    logic [7:0]  wave_bytes[$];
    logic [7:0]  sent[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.io_en = 1'b1; bus.io_we = 1'b1; bus.io_addr = a; bus.io_data_write = d;
        @(posedge clk);
        #1;
        bus.io_en = 1'b0; bus.io_we = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.io_en = 1'b1; bus.io_we = 1'b0; bus.io_addr = a;
        #1;
        d = bus.io_data_read;
        bus.io_en = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    // expected line level k clocks after the first TXDATA write edge
    function automatic logic exp_line(input int k, input int div);
        int idx, fr, bp;
        logic [7:0] b;
        if (k < 2) return 1'b1;
        idx = (k - 2) / div;
        fr  = idx / 10;
        bp  = idx % 10;
        if (fr >= wave_bytes.size()) return 1'b1;
        if (bp == 0) return 1'b0;
        if (bp == 9) return 1'b1;
        b = wave_bytes[fr];
        return b[bp-1];
    endfunction

    // sample the line every clock and compare to the ideal 8N1 waveform
    task automatic wave_test(input string name, input int div);
        int eff, errs, total, first_bad;
        logic got, want;
        eff = (div < 1) ? 1 : div;
        bus_write(8'h10, 32'(div));
        errs = 0; first_bad = -1;
        total = 2 + 10 * wave_bytes.size() * eff + 3;
        fork
            begin
                foreach (wave_bytes[i]) bus_write(8'h08, {24'h0, wave_bytes[i]});
            end
            begin
                @(negedge clk);
                @(posedge clk);
                #1;
                for (int k = 1; k <= total; k++) begin
                    @(posedge clk);
                    #1;
                    got  = uart_tx;
                    want = exp_line(k, eff);
                    if (got !== want) begin
                        errs++;
                        if (first_bad < 0) first_bad = k;
                    end
                end
            end
        join
        if (errs != 0) $display("  %s first bad clock %0d", name, first_bad);
        check(name, 32'(errs), 32'h0);
    endtask

    // receive one 8N1 frame by sampling mid-bit
    task automatic uart_decode(input int div, output logic [7:0] b, output bit ok);
        int w;
        ok = 1'b1; b = 8'h00; w = 0;
        wait_clks(1);
        while (uart_tx !== 1'b0 && w < 400 * div + 400) begin
            wait_clks(1);
            w++;
        end
        if (uart_tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        wait_clks(div / 2);
        if (uart_tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_clks(div);
            b[i] = uart_tx;
        end
        wait_clks(div);
        if (uart_tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic decode_frames(input string name, input int div, input int n);
        logic [7:0] b;
        bit ok;
        for (int i = 0; i < n; i++) begin
            uart_decode(div, b, ok);
            check($sformatf("%s_frame%0d_ok", name, i), {31'h0, ok}, 32'h1);
            if (sent.size() > 0) begin
                check($sformatf("%s_byte%0d", name, i), {24'h0, b}, {24'h0, sent.pop_front()});
            end else begin
                check($sformatf("%s_extra%0d", name, i), {24'h0, b}, 32'hDEAD);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, c0;
        logic [7:0]  m_gpio;
        logic [15:0] m_div;
        int          op, n, div;

        reset = 1'b1;
        gpio_in = 8'h00;
        bus.io_en = 1'b0; bus.io_we = 1'b0; bus.io_addr = 8'h00; bus.io_data_write = 32'h0;

        vecs[0]  = '{1'b1, 1'b0, 8'h00, 32'h0,        32'h0};
        vecs[1]  = '{1'b1, 1'b0, 8'h04, 32'h0,        32'h0};
        vecs[2]  = '{1'b1, 1'b0, 8'h08, 32'h0,        32'h0};
        vecs[3]  = '{1'b1, 1'b0, 8'h0C, 32'h0,        32'h2};
        vecs[4]  = '{1'b1, 1'b0, 8'h10, 32'h0,        32'd104};
        vecs[5]  = '{1'b1, 1'b0, 8'h18, 32'h0,        32'h0};
        vecs[6]  = '{1'b1, 1'b0, 8'h40, 32'h0,        32'h0};
        vecs[7]  = '{1'b1, 1'b1, 8'h00, 32'hFFFFFFFF, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 32'h0,        32'hFF};
        vecs[9]  = '{1'b1, 1'b0, 8'h03, 32'h0,        32'hFF};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 32'h0,        32'h0};
        vecs[11] = '{1'b1, 1'b1, 8'h10, 32'h1234ABCD, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 8'h10, 32'h0,        32'hABCD};
        vecs[13] = '{1'b1, 1'b1, 8'h3C, 32'hFFFFFFFF, 32'h0};
        vecs[14] = '{1'b1, 1'b1, 8'h04, 32'h77,       32'h0};
        vecs[15] = '{1'b1, 1'b0, 8'h04, 32'h0,        32'h0};
        vecs[16] = '{1'b1, 1'b0, 8'h00, 32'h0,        32'hFF};
        vecs[17] = '{1'b1, 1'b1, 8'h02, 32'hA5,       32'h0};
        vecs[18] = '{1'b1, 1'b0, 8'h00, 32'h0,        32'hA5};
        vecs[19] = '{1'b1, 1'b1, 8'h10, 32'h4,        32'h0};
        vecs[20] = '{1'b1, 1'b0, 8'hFC, 32'h0,        32'h0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_uart_idle", {31'h0, uart_tx}, 32'h1);
        check("reset_gpio_out", {24'h0, gpio_out}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // register map vectors
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            bus.io_en = vecs[i].en; bus.io_we = vecs[i].we;
            bus.io_addr = vecs[i].addr; bus.io_data_write = vecs[i].wdata;
            if (vecs[i].en && vecs[i].we) begin
                @(posedge clk);
                #1;
            end else begin
                #1;
                check($sformatf("vec%0d_addr%02h", i, vecs[i].addr), bus.io_data_read, vecs[i].exp);
            end
            bus.io_en = 1'b0; bus.io_we = 1'b0;
        end

        // GPIO out visible next cycle, GPIO in after two synchroniser clocks
        bus_write(8'h00, 32'hFF);
        check("gpio_out_pin", {24'h0, gpio_out}, 32'hFF);
        @(negedge clk);
        gpio_in = 8'h5A;
        read_check("gpio_in_1clk", 8'h04, 32'h0);
        read_check("gpio_in_2clk", 8'h04, 32'h5A);

        // reset in the middle of a frame
        bus_write(8'h08, 32'h00);
        wait_clks(14);
        check("t1_line_low", {31'h0, uart_tx}, 32'h0);
        read_check("t1_status_busy", 8'h0C, 32'h6);
        @(negedge clk);
        reset = 1'b1;
        bus.io_en = 1'b1; bus.io_we = 1'b0; bus.io_addr = 8'h0C;
        #1;
        check("t1_uart_on_reset", {31'h0, uart_tx}, 32'h1);
        check("t1_status_on_reset", bus.io_data_read, 32'h2);
        bus.io_en = 1'b0;
        read_check("t1_div_on_reset", 8'h10, 32'd104);
        check("t1_gpio_on_reset", {24'h0, gpio_out}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        read_check("cycle_after_reset", 8'h14, 32'h1);
        read_check("cycle_next", 8'h14, 32'h2);

        // exact waveform: single byte, then two back-to-back bytes
        wave_bytes = '{8'h55};
        wave_test("t2_wave_55_div4", 4);
        read_check("t2_idle_after", 8'h0C, 32'h2);
        wave_bytes = '{8'hA5, 8'h3C};
        wave_test("t4_wave_back2back_div3", 3);
        read_check("t4_idle_after", 8'h0C, 32'h2);

        // overflow: 10 pushes, first pops, 8 held, 10th dropped
        bus_write(8'h10, 32'h2);
        sent.delete();
        for (int i = 0; i < 9; i++) sent.push_back(8'(8'h10 + i));
        fork
            begin
                for (int i = 0; i < 10; i++) bus_write(8'h08, 32'(8'h10 + i));
                read_check("t3_status_full_ovf", 8'h0C, 32'h80D);
                read_check("t3_txdata_full", 8'h08, 32'h1);
                bus_write(8'h0C, 32'h7);
                read_check("t3_w1c_other_bits", 8'h0C, 32'h80D);
                bus_write(8'h0C, 32'h8);
                read_check("t3_w1c_ovf", 8'h0C, 32'h805);
            end
            decode_frames("t3", 2, 9);
        join
        wait_clks(8);
        read_check("t3_idle_after", 8'h0C, 32'h2);

        // randomized register traffic and UART bursts
        m_gpio = 8'hFF;
        m_div  = 16'h2;
        for (int it = 0; it < 24; it++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    d = $urandom;
                    bus_write(8'h00, d);
                    m_gpio = d[7:0];
                    check("rnd_gpio_pin", {24'h0, gpio_out}, {24'h0, m_gpio});
                    read_check("rnd_gpio_out", 8'h00, {24'h0, m_gpio});
                end
                1: begin
                    d = $urandom;
                    bus_write(8'h10, d);
                    m_div = d[15:0];
                    read_check("rnd_div", 8'h10, {16'h0, m_div});
                end
                2: begin
                    @(negedge clk);
                    gpio_in = 8'($urandom);
                    repeat (2) @(posedge clk);
                    read_check("rnd_gpio_in", 8'h04, {24'h0, gpio_in});
                end
                default: begin
                    div = $urandom_range(0, 4);
                    n   = $urandom_range(1, 8);
                    bus_write(8'h10, 32'(div));
                    m_div = 16'(div);
                    if (div < 1) div = 1;
                    sent.delete();
                    for (int i = 0; i < n; i++) sent.push_back(8'($urandom));
                    wave_bytes = sent;
                    fork
                        begin
                            foreach (wave_bytes[i]) bus_write(8'h08, {24'h0, wave_bytes[i]});
                        end
                        decode_frames("rnd_uart", div, n);
                    join
                    wait_clks(div + 4);
                    read_check("rnd_uart_idle", 8'h0C, 32'h2);
                end
            endcase
        end

        // cycle counter advances exactly one per clock
        bus_read(8'h14, c0);
        repeat (7) @(posedge clk);
        bus_read(8'h14, d);
        check("cycle_delta", d - c0, 32'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
